fpu_f2i_writeback: RTL

Downstream stage of the float-to-integer converter. It captures each converted 32-bit integer result with its destination register index into a 2-entry FIFO and presents it to the integer register-file writeback port over a valid/ready handshake. It also accumulates the converter's invalid and inexact exceptions into the sticky 5-bit fflags register, which the CSR path can read and overwrite.

---
 rtl/fpu_f2i_writeback_if.sv | 34 +++
 rtl/fpu_f2i_writeback.sv | 83 ++++++++
 2 files changed

// File: rtl/fpu_f2i_writeback_if.sv
// Converter-result / register-file writeback / fflags CSR signal bundle.
interface fpu_f2i_writeback_if #(
  parameter int RD_WIDTH = 5,
  parameter int FFLAGS_W = 5
);
  logic                f2i_valid;
  logic                f2i_ready;
  logic [31:0]         f2i_int;
  logic                f2i_invalid;
  logic                f2i_inexact;
  logic [RD_WIDTH-1:0] f2i_rd;
  logic                wb_valid;
  logic                wb_ready;
  logic [31:0]         wb_data;
  logic [RD_WIDTH-1:0] wb_rd;
  logic                csr_fflags_we;
  logic [FFLAGS_W-1:0] csr_fflags_wdata;
  logic [FFLAGS_W-1:0] fflags;
  logic [1:0]          wb_count;

  // Upstream/environment side: produces results, consumes writebacks.
  modport master (
    output f2i_valid, f2i_int, f2i_invalid, f2i_inexact, f2i_rd,
    output wb_ready, csr_fflags_we, csr_fflags_wdata,
    input  f2i_ready, wb_valid, wb_data, wb_rd, fflags, wb_count
  );

  // Writeback stage side.
  modport slave (
    input  f2i_valid, f2i_int, f2i_invalid, f2i_inexact, f2i_rd,
    input  wb_ready, csr_fflags_we, csr_fflags_wdata,
    output f2i_ready, wb_valid, wb_data, wb_rd, fflags, wb_count
  );
endinterface

// File: rtl/fpu_f2i_writeback.sv
// Float-to-int writeback stage: 2-entry result FIFO toward the integer
// register file plus sticky fflags accumulation (NV/NX) with CSR overwrite.
module fpu_f2i_writeback #(
  parameter int RD_WIDTH = 5,
  parameter int FFLAGS_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_l,
  fpu_f2i_writeback_if.slave    bus
);

  logic [31:0]         data_mem [2];
  logic [RD_WIDTH-1:0] rd_mem   [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          count;
  logic [FFLAGS_W-1:0] flags;

  logic                ready;
  logic                accept;
  logic                push;
  logic                pop;
  logic [FFLAGS_W-1:0] acc;

  // Handshake decode; ready looks only at registered occupancy (no full bypass).
  always_comb begin
    ready  = rst_l & (count != 2'd2);
    accept = bus.f2i_valid & ready;
    push   = accept & (bus.f2i_rd != '0);
    pop    = (count != 2'd0) & bus.wb_ready;
    acc    = '0;
    if (accept) begin
      acc[FFLAGS_W-1] = bus.f2i_invalid;
      acc[0]          = bus.f2i_inexact;
    end
  end

  // FIFO storage and pointers; rd==0 results are dropped before the push.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      for (int unsigned i = 0; i < 2; i++) begin
        data_mem[i] <= '0;
        rd_mem[i]   <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= bus.f2i_int;
        rd_mem[wr_ptr]   <= bus.f2i_rd;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Sticky flags; an accept in the CSR-write cycle is ordered after the write.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      flags <= '0;
    end else if (bus.csr_fflags_we) begin
      flags <= bus.csr_fflags_wdata | acc;
    end else begin
      flags <= flags | acc;
    end
  end

  assign bus.f2i_ready = ready;
  assign bus.wb_valid  = (count != 2'd0);
  assign bus.wb_data   = data_mem[rd_ptr];
  assign bus.wb_rd     = rd_mem[rd_ptr];
  assign bus.wb_count  = count;
  assign bus.fflags    = flags;

endmodule
